// File: rtl/mem_arbiter_pkg.sv
// Shared memory-interface types and sizing for the cache-to-memory arbiter.
package mem_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 15;
  localparam int STARVE_LIMIT = 4;

  typedef logic [3:0]  mem_tag_t;
  typedef logic [63:0] mem_block_t;
  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } mem_command_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_owner_entry_t;

endpackage

// File: rtl/mem_tag_table.sv
// Tag-ownership table: records which cache issued each outstanding load tag.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     alloc_en,
  input  mem_tag_t alloc_tag,
  input  logic     alloc_owner,
  input  mem_tag_t lookup_tag,
  output logic     hit_i,
  output logic     hit_d,
  output logic     miss,
  output logic     overwrite
);

  // Entry 0 is never allocated, so tag 0 always reads back as invalid.
  tag_owner_entry_t entry_q [0:NUM_TAGS];
  tag_owner_entry_t entry_d [0:NUM_TAGS];
  tag_owner_entry_t cur;
  logic             lookup_en;
  logic             free_same;

  always_comb begin
    entry_d   = entry_q;
    lookup_en = (lookup_tag != '0);
    cur       = entry_q[lookup_tag];
    hit_i     = lookup_en && cur.valid && (cur.owner == OWNER_I);
    hit_d     = lookup_en && cur.valid && (cur.owner == OWNER_D);
    miss      = lookup_en && !cur.valid;
    free_same = lookup_en && cur.valid && (lookup_tag == alloc_tag);
    overwrite = alloc_en && entry_q[alloc_tag].valid && !free_same;
    if (lookup_en && cur.valid) begin
      entry_d[lookup_tag] = '0;
    end
    // Allocation is applied last so it wins over a same-cycle free.
    if (alloc_en && (alloc_tag != '0)) begin
      entry_d[alloc_tag] = '{valid: 1'b1, owner: alloc_owner};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= NUM_TAGS; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache requests onto one memory port and routes tagged responses back.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        icache_req_valid,
  input  logic [31:0] icache_req_addr,
  input  logic        dcache_req_valid,
  input  logic [1:0]  dcache_req_cmd,
  input  logic [31:0] dcache_req_addr,
  input  logic [63:0] dcache_req_data,
  output logic        icache_req_accepted,
  output logic        dcache_req_accepted,
  output logic [3:0]  req_tag,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_transaction_tag,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_data_tag,
  output logic        icache_resp_valid,
  output logic        dcache_resp_valid,
  output logic [63:0] resp_data,
  output logic [3:0]  resp_tag,
  output logic        orphan_resp
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  logic [2:0]   starve_cnt_q, starve_cnt_d;
  logic         i_win, d_win, accept, alloc_en;
  mem_command_t cmd;
  mem_tag_t     lookup_tag;
  logic         hit_i, hit_d, miss, overwrite;

  always_comb begin
    i_win = !reset && icache_req_valid &&
            (!dcache_req_valid || (starve_cnt_q == STARVE_MAX));
    d_win = !reset && dcache_req_valid && !i_win;

    cmd           = MEM_NONE;
    proc2mem_addr = '0;
    proc2mem_data = '0;
    if (i_win) begin
      cmd           = MEM_LOAD;
      proc2mem_addr = icache_req_addr;
    end else if (d_win) begin
      cmd           = mem_command_t'(dcache_req_cmd);
      proc2mem_addr = dcache_req_addr;
      proc2mem_data = dcache_req_data;
    end
    proc2mem_command = cmd;

    accept              = (cmd != MEM_NONE) && (mem2proc_transaction_tag != '0);
    icache_req_accepted = accept && i_win;
    dcache_req_accepted = accept && d_win;
    req_tag             = accept ? mem2proc_transaction_tag : '0;
    alloc_en            = accept && (cmd == MEM_LOAD);

    // Counts every lost or rejected cycle of a pending I request.
    starve_cnt_d = starve_cnt_q;
    if (!icache_req_valid || icache_req_accepted) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + 3'd1;
    end

    lookup_tag = reset ? '0 : mem2proc_data_tag;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mem_tag_table #(.NUM_TAGS(NUM_MEM_TAGS)) u_tag_table (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (alloc_en),
    .alloc_tag   (mem2proc_transaction_tag),
    .alloc_owner (d_win),
    .lookup_tag  (lookup_tag),
    .hit_i       (hit_i),
    .hit_d       (hit_d),
    .miss        (miss),
    .overwrite   (overwrite)
  );

  assign icache_resp_valid = hit_i;
  assign dcache_resp_valid = hit_d;
  assign orphan_resp       = miss || overwrite;
  assign resp_data         = mem2proc_data;
  assign resp_tag          = mem2proc_data_tag;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected events, a monitor checks them.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        dcache_req_valid;
  logic [1:0]  dcache_req_cmd;
  logic [31:0] dcache_req_addr;
  logic [63:0] dcache_req_data;
  logic        icache_req_accepted;
  logic        dcache_req_accepted;
  logic [3:0]  req_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_data_tag;
  logic        icache_resp_valid;
  logic        dcache_resp_valid;
  logic [63:0] resp_data;
  logic [3:0]  resp_tag;
  logic        orphan_resp;

  localparam logic [1:0] C_NONE  = 2'h0;
  localparam logic [1:0] C_LOAD  = 2'h1;
  localparam logic [1:0] C_STORE = 2'h2;

  typedef struct packed {
    logic        iacc;
    logic        dacc;
    logic [3:0]  tag;
    logic        iresp;
    logic        dresp;
    logic        orphan;
    logic [63:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  mem_arbiter dut (
    .clock                    (clock),
    .reset                    (reset),
    .icache_req_valid         (icache_req_valid),
    .icache_req_addr          (icache_req_addr),
    .dcache_req_valid         (dcache_req_valid),
    .dcache_req_cmd           (dcache_req_cmd),
    .dcache_req_addr          (dcache_req_addr),
    .dcache_req_data          (dcache_req_data),
    .icache_req_accepted      (icache_req_accepted),
    .dcache_req_accepted      (dcache_req_accepted),
    .req_tag                  (req_tag),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data            (mem2proc_data),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .icache_resp_valid        (icache_resp_valid),
    .dcache_resp_valid        (dcache_resp_valid),
    .resp_data                (resp_data),
    .resp_tag                 (resp_tag),
    .orphan_resp              (orphan_resp)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  function automatic ev_t mk(input logic iacc, input logic dacc, input logic [3:0] tag,
                             input logic iresp, input logic dresp, input logic orphan,
                             input logic [63:0] data);
    ev_t e;
    e.iacc = iacc; e.dacc = dacc; e.tag = tag;
    e.iresp = iresp; e.dresp = dresp; e.orphan = orphan; e.data = data;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [3:0] tt, input logic [3:0] rt, input logic [63:0] rd);
    icache_req_valid = iv; icache_req_addr = ia;
    dcache_req_valid = dv; dcache_req_cmd = dc; dcache_req_addr = da; dcache_req_data = dd;
    mem2proc_transaction_tag = tt; mem2proc_data_tag = rt; mem2proc_data = rd;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd0, '0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: any visible handshake or response event must match the head of the queue.
  always @(negedge clock) begin
    ev_t act, e;
    if (!reset && (icache_req_accepted || dcache_req_accepted || icache_resp_valid ||
                   dcache_resp_valid || orphan_resp)) begin
      act = mk(icache_req_accepted, dcache_req_accepted, req_tag, icache_resp_valid,
               dcache_resp_valid, orphan_resp,
               (icache_resp_valid || dcache_resp_valid) ? resp_data : 64'h0);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event actual=%h required=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL event actual=%h required=%h", act, e);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    step();
    // Requests and tags presented during reset must be ignored.
    drive(1'b1, 32'h80, 1'b1, C_LOAD, 32'h90, '0, 4'd9, 4'd1, 64'h1);
    @(negedge clock);
    chk("reset_cmd", {62'h0, proc2mem_command}, {62'h0, C_NONE});
    chk("reset_outs", {58'h0, icache_req_accepted, dcache_req_accepted, icache_resp_valid,
                       dcache_resp_valid, orphan_resp, 1'b0},
        64'h0);
    chk("reset_req_tag", {60'h0, req_tag}, 64'h0);
    chk("reset_starve", {61'h0, dut.starve_cnt_q}, 64'h0);
    step();
    reset = 1'b0;
    idle();
    @(negedge clock);
    chk("idle_cmd", {62'h0, proc2mem_command}, {62'h0, C_NONE});
    chk("idle_addr", {32'h0, proc2mem_addr}, 64'h0);
    chk("idle_data", proc2mem_data, 64'h0);
    step();

    // D load tag 3, response two cycles later, then a repeat response must be orphaned.
    drive(1'b0, '0, 1'b1, C_LOAD, 32'h100, '0, 4'd3, 4'd0, '0);
    exp_q.push_back(mk(0, 1, 4'd3, 0, 0, 0, 64'h0));
    @(negedge clock);
    chk("dload_cmd", {62'h0, proc2mem_command}, {62'h0, C_LOAD});
    chk("dload_addr", {32'h0, proc2mem_addr}, 64'h100);
    step();
    idle();
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd3, 64'hDEAD);
    exp_q.push_back(mk(0, 0, 4'd0, 0, 1, 0, 64'hDEAD));
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd3, 64'hDEAD);
    exp_q.push_back(mk(0, 0, 4'd0, 0, 0, 1, 64'h0));
    step();

    // Both valid: D wins four times, then the starved I request is forced through.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h200, 1'b1, C_LOAD, 32'h300, '0, 4'(k + 1), 4'd0, '0);
      if (k < 4) begin
        exp_q.push_back(mk(0, 1, 4'(k + 1), 0, 0, 0, 64'h0));
      end else begin
        chk("starve_at_limit", {61'h0, dut.starve_cnt_q}, 64'd4);
        exp_q.push_back(mk(1, 0, 4'd5, 0, 0, 0, 64'h0));
        @(negedge clock);
        chk("starve_win_addr", {32'h0, proc2mem_addr}, 64'h200);
      end
      step();
    end
    idle();
    chk("starve_cleared", {61'h0, dut.starve_cnt_q}, 64'd0);

    // Return tags 1,3,4 (D-owned) and 5 (I-owned); tag 2 stays outstanding.
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd1, 64'h11);
    exp_q.push_back(mk(0, 0, 4'd0, 0, 1, 0, 64'h11));
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd3, 64'h33);
    exp_q.push_back(mk(0, 0, 4'd0, 0, 1, 0, 64'h33));
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd4, 64'h44);
    exp_q.push_back(mk(0, 0, 4'd0, 0, 1, 0, 64'h44));
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd5, 64'h55);
    exp_q.push_back(mk(0, 0, 4'd0, 1, 0, 0, 64'h55));
    step();

    // D store allocates nothing, so its tag's response is an orphan.
    drive(1'b0, '0, 1'b1, C_STORE, 32'h400, 64'hCAFE_F00D, 4'd5, 4'd0, '0);
    exp_q.push_back(mk(0, 1, 4'd5, 0, 0, 0, 64'h0));
    @(negedge clock);
    chk("store_cmd", {62'h0, proc2mem_command}, {62'h0, C_STORE});
    chk("store_data", proc2mem_data, 64'hCAFE_F00D);
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd5, 64'h5);
    exp_q.push_back(mk(0, 0, 4'd0, 0, 0, 1, 64'h0));
    step();

    // Free of tag 2 (D owner) and I allocation of tag 2 in the same cycle.
    drive(1'b1, 32'h500, 1'b0, C_NONE, '0, '0, 4'd2, 4'd2, 64'hBEEF);
    exp_q.push_back(mk(1, 0, 4'd2, 0, 1, 0, 64'hBEEF));
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd2, 64'h22);
    exp_q.push_back(mk(0, 0, 4'd0, 1, 0, 0, 64'h22));
    step();

    // Allocating an already-valid tag overwrites the owner and flags orphan.
    drive(1'b0, '0, 1'b1, C_LOAD, 32'h700, '0, 4'd8, 4'd0, '0);
    exp_q.push_back(mk(0, 1, 4'd8, 0, 0, 0, 64'h0));
    step();
    drive(1'b1, 32'h780, 1'b0, C_NONE, '0, '0, 4'd8, 4'd0, '0);
    exp_q.push_back(mk(1, 0, 4'd8, 0, 0, 1, 64'h0));
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd8, 64'h88);
    exp_q.push_back(mk(0, 0, 4'd0, 1, 0, 0, 64'h88));
    step();

    // Memory rejects three times; D holds its request and is accepted with tag 7.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, C_LOAD, 32'h600, '0, 4'd0, 4'd0, '0);
      @(negedge clock);
      chk("reject_cmd", {62'h0, proc2mem_command}, {62'h0, C_LOAD});
      chk("reject_addr", {32'h0, proc2mem_addr}, 64'h600);
      chk("reject_acc", {62'h0, icache_req_accepted, dcache_req_accepted}, 64'h0);
      step();
    end
    drive(1'b0, '0, 1'b1, C_LOAD, 32'h600, '0, 4'd7, 4'd0, '0);
    exp_q.push_back(mk(0, 1, 4'd7, 0, 0, 0, 64'h0));
    step();
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd7, 64'h77);
    exp_q.push_back(mk(0, 0, 4'd0, 0, 1, 0, 64'h77));
    step();

    // Outstanding D load tag 6 is discarded by a mid-run reset.
    drive(1'b0, '0, 1'b1, C_LOAD, 32'h900, '0, 4'd6, 4'd0, '0);
    exp_q.push_back(mk(0, 1, 4'd6, 0, 0, 0, 64'h0));
    step();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0, C_NONE, '0, '0, 4'd0, 4'd6, 64'h66);
    exp_q.push_back(mk(0, 0, 4'd0, 0, 0, 1, 64'h0));
    step();
    idle();
    step();
    step();

    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the cache request interfaces. Arbitrates I-cache and D-cache requests onto the single memory port and returns the accepted/tag handshake to the granted requester.
- Keeps a tag-ownership table so each tagged memory response reaches the cache that issued the load.
- Sits between Icache/Dcache_subsystem and mem.

Parameters:
- NUM_TAGS, `NUM_MEM_TAGS (15): number of non-zero memory tags. Table index 1..NUM_TAGS; tag 0 means "none".
- STARVE_LIMIT, 4: number of consecutive cycles the I-cache can lose arbitration before it is forced to win.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
icache_req_valid  in  1  I-cache load request
icache_req_addr  in  32  block-aligned address (ADDR)
dcache_req_valid  in  1  D-cache request
dcache_req_cmd  in  2  MEM_COMMAND: MEM_LOAD or MEM_STORE
dcache_req_addr  in  32  block-aligned address
dcache_req_data  in  64  MEM_BLOCK store data
icache_req_accepted  out  1  I request taken by memory this cycle
dcache_req_accepted  out  1  D request taken by memory this cycle
req_tag  out  4  MEM_TAG given to the granted requester this cycle
proc2mem_command  out  2  MEM_COMMAND to memory
proc2mem_addr  out  32  address to memory
proc2mem_data  out  64  store data to memory
mem2proc_transaction_tag  in  4  non-zero = this cycle's command accepted with this tag
mem2proc_data  in  64  response data
mem2proc_data_tag  in  4  non-zero = response valid for this tag
icache_resp_valid  out  1  response routed to I-cache
dcache_resp_valid  out  1  response routed to D-cache
resp_data  out  64  mem2proc_data passthrough
resp_tag  out  4  mem2proc_data_tag passthrough
orphan_resp  out  1  response tag had no valid owner entry (pulse)

Behaviour:
Interface rule:
- One clock; reset is synchronous and active-high, ports named clock and reset.

Arbitration (combinational from registered state):
- D-cache wins by default.
- I-cache wins when D is idle, or when starve_cnt == STARVE_LIMIT and icache_req_valid.
- starve_cnt (registered) behaviour:
  - +1 in each cycle I is valid and not accepted; saturates at STARVE_LIMIT.
  - Cleared when an I request is accepted or icache_req_valid is low.
- Winner's command, address and data drive proc2mem_*. With no request, proc2mem_command = MEM_NONE, addr = 0, data = 0.
- I-cache always issues MEM_LOAD.

Handshake:
- Accept occurs when the driven command is not MEM_NONE and mem2proc_transaction_tag != 0, in the same cycle, zero latency.
- On accept, winner's *_req_accepted = 1 and req_tag = mem2proc_transaction_tag. Otherwise both accepted = 0 and req_tag = 0.
- The loser sees accepted = 0 and must hold its request.
- A rejected winner keeps priority next cycle; the starve counter still advances for I.

Ownership table (NUM_TAGS entries, each valid + owner bit, 0 = I, 1 = D):
- Accepted MEM_LOAD sets entry[tag] = {1, owner}.
- Accepted MEM_STORE allocates nothing.
- Response with mem2proc_data_tag = t != 0:
  - If entry[t] is valid, assert the owner's *_resp_valid the same cycle and clear entry[t] at the clock edge.
  - If entry[t] is invalid, assert orphan_resp and no resp_valid.
- Same-cycle free and allocate of the same tag: allocation wins, so the entry is valid with the new owner.
- Allocation to an already-valid tag overwrites the entry and asserts orphan_resp, flagging a protocol violation.

Reset:
- All table entries are invalid and starve_cnt = 0.
- While reset is high: proc2mem_command = MEM_NONE, all accepted/resp_valid = 0, req_tag = 0, orphan_resp = 0.
- Mid-operation reset discards outstanding entries. Later responses for those tags raise orphan_resp and are dropped.

Decomposition:
- Shared (sys_defs.svh): MEM_TAG, MEM_BLOCK, ADDR, MEM_COMMAND, `NUM_MEM_TAGS, plus a new typedef TAG_OWNER_ENTRY {valid, owner}.
- One sub-module, mem_tag_table: alloc port, lookup/free port and same-cycle priority rule. The arbiter plus starve counter stays in the top module.

Test Plan:
- D load at 0x100 with mem tag 3 → dcache_req_accepted = 1, req_tag = 3. Two cycles later, data_tag = 3 with data 0xDEAD → dcache_resp_valid = 1, resp_data = 0xDEAD, entry 3 cleared.
- I and D both valid for 4 cycles with every request accepted (tags 1..4) → D wins cycles 0-3 (starve_cnt reaches 4). I wins cycle 4, and its starve_cnt = 0 the next cycle.
- D store with tag 5 accepted, then data_tag = 5 returns → no resp_valid, orphan_resp = 1.
- Response for tag 2 frees entry 2 in the same cycle as an I load allocates tag 2 → entry 2 valid, owner I. A later tag-2 response goes to the I-cache.
- Memory rejects (transaction_tag = 0) for 3 cycles → accepted stays 0, D holds its request, accepted on the 4th cycle with tag 7.
- Outstanding D load tag 6, assert reset for 1 cycle, then data_tag = 6 arrives → orphan_resp = 1, dcache_resp_valid = 0.
